// File: rtl/bayer_gain_pipe.sv
// rtl/bayer_gain_pipe.sv - Bayer black-level subtraction and per-channel gain, 2-stage stream pipeline
// Define BAYER_GAIN_STATS_EN to build the per-channel output pixel sums and stat_valid_o pulse.
module bayer_gain_pipe #(
    parameter int DATA_WIDTH = 12,
    parameter int GAIN_WIDTH = 12,
    parameter int GAIN_FRAC  = 8,
    parameter int POS_WIDTH  = 13
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cfg_enable_i,
    input  logic [1:0]                cfg_pattern_i,
    input  logic [4*DATA_WIDTH-1:0]   cfg_offset_i,
    input  logic [4*GAIN_WIDTH-1:0]   cfg_gain_i,
    input  logic                      cfg_update_i,
    input  logic [DATA_WIDTH-1:0]     s_data_i,
    input  logic                      s_valid_i,
    input  logic                      s_sop_i,
    input  logic                      s_eol_i,
    input  logic                      s_eof_i,
    output logic                      s_ready_o,
    output logic [DATA_WIDTH-1:0]     m_data_o,
    output logic                      m_valid_o,
    output logic                      m_sop_o,
    output logic                      m_eol_o,
    output logic                      m_eof_o,
    output logic [1:0]                m_channel_o,
    input  logic                      m_ready_i,
    output logic [31:0]               sat_count_o,
    output logic [4*32-1:0]           stat_sum_o,
    output logic                      stat_valid_o
);
    localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic [PROD_WIDTH-1:0] ROUND_BIAS = PROD_WIDTH'(1) << (GAIN_FRAC - 1);
    localparam logic [PROD_WIDTH-1:0] PIX_LIMIT  = PROD_WIDTH'({DATA_WIDTH{1'b1}});

    logic                    advance, accept, load, sat;
    logic [1:0]              pat_eff, ch;
    logic [4*DATA_WIDTH-1:0] off_eff;
    logic [4*GAIN_WIDTH-1:0] gain_eff;
    logic [DATA_WIDTH-1:0]   off_sel;
    logic [POS_WIDTH-1:0]    pos_x, pos_y;
    logic [PROD_WIDTH-1:0]   prod, scaled;

    logic                    pending_q, pending_d;
    logic [1:0]              act_pat_q, act_pat_d;
    logic [4*DATA_WIDTH-1:0] act_off_q, act_off_d;
    logic [4*GAIN_WIDTH-1:0] act_gain_q, act_gain_d;
    logic [POS_WIDTH-1:0]    x_q, x_d, y_q, y_d;

    logic                    s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d;
    logic                    s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d, s1_en_q, s1_en_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [1:0]              s1_ch_q, s1_ch_d;
    logic [GAIN_WIDTH-1:0]   s1_gain_q, s1_gain_d;

    logic                    m_valid_q, m_valid_d, m_sop_q, m_sop_d;
    logic                    m_eol_q, m_eol_d, m_eof_q, m_eof_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [1:0]              m_ch_q, m_ch_d;
    logic [31:0]             sat_count_q, sat_count_d;

    always_comb begin
        advance = !m_valid_q || m_ready_i;
        accept  = s_valid_i && advance;
        // A pending (or same-cycle) update is applied exactly at an accepted sop beat.
        load    = accept && s_sop_i && (pending_q || cfg_update_i);

        pat_eff  = load ? cfg_pattern_i : act_pat_q;
        off_eff  = load ? cfg_offset_i  : act_off_q;
        gain_eff = load ? cfg_gain_i    : act_gain_q;

        pos_x   = s_sop_i ? '0 : x_q;
        pos_y   = s_sop_i ? '0 : y_q;
        ch      = {pos_y[0], pos_x[0]} ^ pat_eff;
        off_sel = off_eff[int'(ch)*DATA_WIDTH +: DATA_WIDTH];

        pending_d  = (pending_q || cfg_update_i) && !load;
        act_pat_d  = pat_eff;
        act_off_d  = off_eff;
        act_gain_d = gain_eff;

        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            x_d = s_eol_i ? '0 : pos_x + POS_WIDTH'(1);
            y_d = s_eol_i ? pos_y + POS_WIDTH'(1) : pos_y;
        end

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sop_d   = s1_sop_q;
        s1_eol_d   = s1_eol_q;
        s1_eof_d   = s1_eof_q;
        s1_ch_d    = s1_ch_q;
        s1_en_d    = s1_en_q;
        s1_gain_d  = s1_gain_q;
        if (advance) begin
            s1_valid_d = s_valid_i;
            if (!cfg_enable_i)
                s1_data_d = s_data_i;
            else if (s_data_i < off_sel)
                s1_data_d = '0;
            else
                s1_data_d = s_data_i - off_sel;
            s1_sop_d  = s_sop_i;
            s1_eol_d  = s_eol_i;
            s1_eof_d  = s_eof_i;
            s1_ch_d   = ch;
            s1_en_d   = cfg_enable_i;
            // Gain travels with the pixel so a config load at a new sop cannot touch the previous frame's tail.
            s1_gain_d = gain_eff[int'(ch)*GAIN_WIDTH +: GAIN_WIDTH];
        end

        prod   = PROD_WIDTH'(s1_data_q) * PROD_WIDTH'(s1_gain_q) + ROUND_BIAS;
        scaled = prod >> GAIN_FRAC;
        sat    = s1_en_q && (scaled > PIX_LIMIT);

        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_sop_d     = m_sop_q;
        m_eol_d     = m_eol_q;
        m_eof_d     = m_eof_q;
        m_ch_d      = m_ch_q;
        sat_count_d = sat_count_q;
        if (advance) begin
            m_valid_d = s1_valid_q;
            if (!s1_en_q)
                m_data_d = s1_data_q;
            else if (sat)
                m_data_d = '1;
            else
                m_data_d = scaled[DATA_WIDTH-1:0];
            m_sop_d = s1_sop_q;
            m_eol_d = s1_eol_q;
            m_eof_d = s1_eof_q;
            m_ch_d  = s1_ch_q;
            if (s1_valid_q) begin
                if (s1_sop_q)
                    sat_count_d = {31'b0, sat};
                else if (sat && sat_count_q != '1)
                    sat_count_d = sat_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q   <= 1'b0;
            act_pat_q   <= 2'd0;
            act_off_q   <= '0;
            act_gain_q  <= {4{GAIN_UNITY}};
            x_q         <= '0;
            y_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sop_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_ch_q     <= 2'd0;
            s1_en_q     <= 1'b0;
            s1_gain_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sop_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            m_ch_q      <= 2'd0;
            sat_count_q <= '0;
        end else begin
            pending_q   <= pending_d;
            act_pat_q   <= act_pat_d;
            act_off_q   <= act_off_d;
            act_gain_q  <= act_gain_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sop_q    <= s1_sop_d;
            s1_eol_q    <= s1_eol_d;
            s1_eof_q    <= s1_eof_d;
            s1_ch_q     <= s1_ch_d;
            s1_en_q     <= s1_en_d;
            s1_gain_q   <= s1_gain_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sop_q     <= m_sop_d;
            m_eol_q     <= m_eol_d;
            m_eof_q     <= m_eof_d;
            m_ch_q      <= m_ch_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign s_ready_o   = advance;
    assign m_valid_o   = m_valid_q;
    assign m_data_o    = m_data_q;
    assign m_sop_o     = m_sop_q;
    assign m_eol_o     = m_eol_q;
    assign m_eof_o     = m_eof_q;
    assign m_channel_o = m_ch_q;
    assign sat_count_o = sat_count_q;

`ifdef BAYER_GAIN_STATS_EN
    logic            out_xfer;
    logic [4*32-1:0] stat_sum_q, stat_sum_d;
    logic            stat_valid_q, stat_valid_d;

    always_comb begin
        out_xfer     = m_valid_q && m_ready_i;
        stat_sum_d   = stat_sum_q;
        stat_valid_d = out_xfer && m_eof_q;
        if (out_xfer) begin
            if (m_sop_q)
                stat_sum_d = '0;
            stat_sum_d[int'(m_ch_q)*32 +: 32] = stat_sum_d[int'(m_ch_q)*32 +: 32] + 32'(m_data_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_sum_q   <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            stat_sum_q   <= stat_sum_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign stat_sum_o   = stat_sum_q;
    assign stat_valid_o = stat_valid_q;
`else
    assign stat_sum_o   = '0;
    assign stat_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_bayer_gain_pipe.sv
// tb/tb_bayer_gain_pipe.sv - randomized self-checking bench for bayer_gain_pipe against a frame-level model
`timescale 1ns/1ps
module tb_bayer_gain_pipe;
    localparam int DW = 12;
    localparam int GW = 12;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            cfg_enable_i, cfg_update_i;
    logic [1:0]      cfg_pattern_i;
    logic [4*DW-1:0] cfg_offset_i;
    logic [4*GW-1:0] cfg_gain_i;
    logic [DW-1:0]   s_data_i, m_data_o;
    logic            s_valid_i, s_sop_i, s_eol_i, s_eof_i, s_ready_o;
    logic            m_valid_o, m_sop_o, m_eol_o, m_eof_o, m_ready_i;
    logic [1:0]      m_channel_o;
    logic [31:0]     sat_count_o;
    logic [127:0]    stat_sum_o;
    logic            stat_valid_o;

    always #5 clk_i = ~clk_i;

    bayer_gain_pipe dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cfg_enable_i(cfg_enable_i), .cfg_pattern_i(cfg_pattern_i),
        .cfg_offset_i(cfg_offset_i), .cfg_gain_i(cfg_gain_i), .cfg_update_i(cfg_update_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_sop_i(s_sop_i),
        .s_eol_i(s_eol_i), .s_eof_i(s_eof_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_sop_o(m_sop_o),
        .m_eol_o(m_eol_o), .m_eof_o(m_eof_o), .m_channel_o(m_channel_o), .m_ready_i(m_ready_i),
        .sat_count_o(sat_count_o), .stat_sum_o(stat_sum_o), .stat_valid_o(stat_valid_o)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    ch;
        logic          sop;
        logic          eol;
        logic          eof;
    } beat_t;

    beat_t  rx[$];
    beat_t  exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     sh_pat, act_pat, mx, my;
    int     sh_off[4], sh_gain[4], act_off[4], act_gain[4];
    bit     pend;
    longint m_sat;

    // Output transfers are recorded on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk_i)
        if (rst_n_i && m_valid_o && m_ready_i)
            rx.push_back(beat_t'({m_data_o, m_channel_o, m_sop_o, m_eol_o, m_eof_o}));

    task automatic drive_cfg();
        cfg_pattern_i = 2'(sh_pat);
        for (int i = 0; i < 4; i++) begin
            cfg_offset_i[i*DW +: DW] = DW'(sh_off[i]);
            cfg_gain_i[i*GW +: GW]   = GW'(sh_gain[i]);
        end
    endtask

    task automatic set_shadow(input int pat, input int off, input int gain);
        sh_pat = pat;
        for (int i = 0; i < 4; i++) begin
            sh_off[i]  = off;
            sh_gain[i] = gain;
        end
        drive_cfg();
    endtask

    task automatic model_reset();
        act_pat = 0;
        for (int i = 0; i < 4; i++) begin
            act_off[i]  = 0;
            act_gain[i] = 256;
        end
        pend = 0; mx = 0; my = 0; m_sat = 0;
    endtask

    task automatic pulse_update();
        cfg_update_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_update_i = 1'b0;
        pend = 1;
    endtask

    // Predict the beat from frame-level rules, then present it until accepted.
    task automatic push(input int d, input bit sop, input bit eol, input bit eof, input bit upd);
        int x, y, ch, b, r;
        bit sat, acc;
        if (sop && (pend || upd)) begin
            act_pat = sh_pat; act_off = sh_off; act_gain = sh_gain; pend = 0;
        end
        x  = sop ? 0 : mx;
        y  = sop ? 0 : my;
        ch = ((y % 2) * 2 + (x % 2)) ^ act_pat;
        sat = 0;
        if (cfg_enable_i) begin
            b = (d > act_off[ch]) ? d - act_off[ch] : 0;
            r = (b * act_gain[ch] + 128) / 256;
            if (r > 4095) begin r = 4095; sat = 1; end
        end else r = d;
        if (sop) m_sat = sat;
        else if (sat && m_sat < 64'hFFFF_FFFF) m_sat++;
        if (eol) begin mx = 0; my = (y + 1) % 8192; end
        else begin mx = (x + 1) % 8192; my = y; end
        exp_q.push_back(beat_t'({DW'(r), 2'(ch), sop, eol, eof}));

        s_data_i = DW'(d); s_sop_i = sop; s_eol_i = eol; s_eof_i = eof;
        s_valid_i = 1'b1;
        if (upd) cfg_update_i = 1'b1;
        acc = 0;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk_i); acc = s_ready_o;
            @(posedge clk_i); #1;
        end
        s_valid_i = 1'b0;
        if (upd) cfg_update_i = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL send_accept: s_ready_o never high, required 1"); end
    endtask

    task automatic wait_rx(input int n);
        for (int t = 0; t < 3000 && rx.size() < n; t++) begin @(posedge clk_i); #1; end
        checks++;
        if (rx.size() < n) begin errors++; $display("FAIL rx_count: got %0d beats, required %0d", rx.size(), n); end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid_o); end
        checks++; if (sat_count_o !== 32'd0) begin errors++; $display("FAIL reset_sat_count: got %0d required 0", sat_count_o); end
        checks++; if (stat_sum_o !== '0 || stat_valid_o !== 1'b0) begin errors++; $display("FAIL reset_stats: got %h/%b required 0/0", stat_sum_o, stat_valid_o); end
        @(negedge clk_i); rst_n_i = 1'b1;
        model_reset();
        @(posedge clk_i); #1;
        checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready_o); end
    endtask

    task automatic test_blc_gain();
        rx.delete(); exp_q.delete();
        set_shadow(0, 0, 256);
        sh_off[0] = 64; sh_gain[0] = 'h180; drive_cfg();
        pulse_update();
        push(1000, 1, 1, 1, 0);
        @(negedge clk_i);
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL latency_early: m_valid_o=%b required 0", m_valid_o); end
        @(negedge clk_i);
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL latency_2: m_valid_o=%b required 1", m_valid_o); end
        checks++; if (m_data_o !== 12'd1404 || m_channel_o !== 2'd0) begin errors++; $display("FAIL blc_gain: got %0d ch %0d required 1404 ch 0", m_data_o, m_channel_o); end
        checks++; if ({m_sop_o, m_eol_o, m_eof_o} !== 3'b111) begin errors++; $display("FAIL blc_sideband: got %b required 111", {m_sop_o, m_eol_o, m_eof_o}); end
        wait_rx(1);
    endtask

    task automatic test_saturation();
        int want[3];
        want = '{4095, 0, 4000};
        rx.delete(); exp_q.delete();
        set_shadow(0, 0, 'h200);
        pulse_update();
        push(4000, 1, 1, 1, 0);
        wait_rx(1);
        checks++; if (sat_count_o !== 32'(m_sat) || m_sat != 1) begin errors++; $display("FAIL sat_count_one: got %0d required 1", sat_count_o); end
        sh_off[0] = 64; drive_cfg(); pulse_update();
        push(30, 1, 1, 1, 0);
        wait_rx(2);
        checks++; if (sat_count_o !== 32'(m_sat)) begin errors++; $display("FAIL sat_count_clear: got %0d required %0d", sat_count_o, m_sat); end
        cfg_enable_i = 1'b0;
        push(4000, 1, 1, 1, 0);
        cfg_enable_i = 1'b1;
        wait_rx(3);
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i] || rx[i].d !== DW'(want[i])) begin errors++; $display("FAIL sat_stream[%0d]: got %p required %p", i, rx[i], exp_q[i]); end
        end
        checks++; if (sat_count_o !== 32'd0) begin errors++; $display("FAIL bypass_sat: got %0d required 0", sat_count_o); end
    endtask

    task automatic test_back_to_back_stall();
        logic [DW-1:0] held;
        rx.delete(); exp_q.delete();
        set_shadow(0, 0, 256);
        pulse_update();
        fork
            for (int i = 0; i < 16; i++) push(100 + i, i == 0, i == 15, i == 15, 0);
            begin
                repeat (4) @(posedge clk_i);
                #1 m_ready_i = 1'b0;
                @(negedge clk_i); held = m_data_o;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk_i);
                    checks++;
                    if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1 || m_data_o !== held) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: s_ready=%b m_valid=%b data=%0d required 0/1/%0d", c, s_ready_o, m_valid_o, m_data_o, held);
                    end
                end
                @(posedge clk_i); #1 m_ready_i = 1'b1;
            end
        join
        wait_rx(16);
        checks++; if (rx.size() != 16) begin errors++; $display("FAIL stall_count: got %0d required 16", rx.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL stall_stream[%0d]: got %p required %p", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_frames();
        bit done;
        rx.delete(); exp_q.delete();
        done = 0;
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    int w, h;
                    sh_pat = $urandom_range(0, 3);
                    for (int i = 0; i < 4; i++) begin
                        sh_off[i]  = $urandom_range(0, 255);
                        sh_gain[i] = $urandom_range(64, 1023);
                    end
                    drive_cfg();
                    if (f % 2 == 0) pulse_update();
                    w = $urandom_range(2, 5);
                    h = $urandom_range(2, 3);
                    for (int y = 0; y < h; y++)
                        for (int x = 0; x < w; x++) begin
                            cfg_enable_i = ($urandom_range(0, 4) != 0);
                            if ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
                            push($urandom_range(0, 4095), x == 0 && y == 0, x == w - 1,
                                 x == w - 1 && y == h - 1, (f % 2 == 1) && x == 0 && y == 0);
                        end
                end
                cfg_enable_i = 1'b1;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i); #1;
                    m_ready_i = ($urandom_range(0, 3) != 0);
                end
                m_ready_i = 1'b1;
            end
        join
        wait_rx(exp_q.size());
        checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d required %0d", rx.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL rand_stream[%0d]: got %p required %p", i, rx[i], exp_q[i]); end
        end
        checks++; if (sat_count_o !== 32'(m_sat)) begin errors++; $display("FAIL rand_sat_count: got %0d required %0d", sat_count_o, m_sat); end
    endtask

    task automatic test_cfg_update();
        rx.delete(); exp_q.delete();
        set_shadow(0, 0, 256);
        pulse_update();
        push(500, 1, 0, 0, 0);
        sh_gain[0] = 'h200; drive_cfg();
        pulse_update();
        push(600, 0, 1, 0, 0);
        push(700, 0, 0, 0, 0);
        push(800, 0, 1, 1, 0);
        push(500, 1, 0, 0, 0);
        push(600, 0, 1, 0, 0);
        push(700, 0, 0, 0, 0);
        push(800, 0, 1, 1, 0);
        wait_rx(8);
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL cfg_stream[%0d]: got %p required %p", i, rx[i], exp_q[i]); end
        end
        checks++; if (rx.size() < 8 || rx[0].d !== 12'd500 || rx[4].d !== 12'd1000) begin errors++; $display("FAIL cfg_frame_boundary: R pixels not 500 then 1000"); end
    endtask

    task automatic test_bggr_stats();
        logic [127:0] sums;
        int           want_ch[4];
        want_ch = '{3, 2, 1, 0};
        rx.delete(); exp_q.delete();
        set_shadow(3, 0, 256);
        pulse_update();
        push(10, 1, 0, 0, 0);
        push(20, 0, 1, 0, 0);
        push(30, 0, 0, 0, 0);
        push(40, 0, 1, 1, 0);
        wait_rx(4);
        sums = '0;
        for (int i = 0; i < exp_q.size(); i++)
            sums[int'(exp_q[i].ch)*32 +: 32] += 32'(exp_q[i].d);
`ifdef BAYER_GAIN_STATS_EN
        checks++; if (stat_valid_o !== 1'b1) begin errors++; $display("FAIL stat_valid_pulse: got %b required 1", stat_valid_o); end
        checks++; if (stat_sum_o !== sums) begin errors++; $display("FAIL stat_sums: got %h required %h", stat_sum_o, sums); end
        @(posedge clk_i); #1;
        checks++; if (stat_valid_o !== 1'b0 || stat_sum_o !== sums) begin errors++; $display("FAIL stat_hold: valid=%b sums=%h required 0/%h", stat_valid_o, stat_sum_o, sums); end
`else
        checks++; if (stat_valid_o !== 1'b0 || stat_sum_o !== '0) begin errors++; $display("FAIL stats_off: got %b/%h required 0/0 (sums would be %h)", stat_valid_o, stat_sum_o, sums); end
`endif
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i] || rx[i].ch !== 2'(want_ch[i])) begin errors++; $display("FAIL bggr_stream[%0d]: got %p required %p", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_inflight();
        rx.delete(); exp_q.delete();
        set_shadow(0, 0, 'h200);
        pulse_update();
        push(100, 1, 0, 0, 0);
        push(200, 0, 0, 0, 0);
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL inflight_setup: m_valid_o=%b required 1", m_valid_o); end
        rst_n_i = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0 || sat_count_o !== 32'd0) begin errors++; $display("FAIL reset_immediate: m_valid=%b sat=%0d required 0/0", m_valid_o, sat_count_o); end
        @(negedge clk_i); rst_n_i = 1'b1;
        model_reset();
        rx.delete(); exp_q.delete();
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_stale: m_valid_o=%b required 0", m_valid_o); end
        push(1000, 1, 1, 1, 0);
        wait_rx(1);
        repeat (4) @(posedge clk_i);
        checks++; if (rx.size() != 1 || rx[0] !== exp_q[0] || rx[0].d !== 12'd1000) begin errors++; $display("FAIL reset_unity: got %0d beats first %p required 1 beat d=1000", rx.size(), rx.size() > 0 ? rx[0] : beat_t'(0)); end
    endtask

    initial begin
        cfg_enable_i = 1'b1; cfg_update_i = 1'b0;
        s_data_i = '0; s_valid_i = 1'b0; s_sop_i = 1'b0; s_eol_i = 1'b0; s_eof_i = 1'b0;
        m_ready_i = 1'b1;
        set_shadow(0, 0, 256);
        model_reset();
        test_reset();
        test_blc_gain();
        test_saturation();
        test_back_to_back_stall();
        test_cfg_update();
        test_bggr_stats();
        test_random_frames();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
